// File: rtl/snes_poller.sv
// snes_poller: polls two SNES-style pads over a shared latch/clock pair
// and publishes per-poll 12-bit button words with a one-cycle valid.
module snes_poller #(
  parameter int LATCH_CYC = 288,
  parameter int HALF      = 144,
  parameter int PERIOD    = 400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1ser,
  input  logic        p2ser,
  output logic        latch,
  output logic        pclk,
  output logic [11:0] p1data,
  output logic [11:0] p2data,
  output logic        valid
);

  localparam int MAXC = (LATCH_CYC > HALF) ? LATCH_CYC : HALF;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int TW   = $clog2(PERIOD);

  typedef enum logic [2:0] {
    IDLE, LATCH, GAP, LOW, HIGH, DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    n, n_nx;
  logic [TW-1:0] timer;
  logic [1:0]    s1, s2;
  logic [11:0]   sh1, sh2;
  logic          samp;
  logic          last;
  logic          fin;
  logic [3:0]    idx;

  // two-flop synchronizers; idle level of an unpressed line is high
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= {p2ser, p1ser};
      s2 <= s1;
    end
  end

  // free-running poll timer, wraps at PERIOD
  always_ff @(posedge clk) begin
    if (reset || timer == TW'(PERIOD - 1))
      timer <= '0;
    else
      timer <= timer + TW'(1);
  end

  // next-state, phase counting and pad-facing outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    n_nx     = n;
    samp     = 1'b0;
    last     = 1'b0;
    fin      = 1'b0;
    latch    = 1'b0;
    pclk     = 1'b1;
    valid    = 1'b0;
    idx      = n[3:0];
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (timer == '0) state_nx = LATCH;
      end
      LATCH: begin
        latch = 1'b1;
        last  = (cnt == CW'(LATCH_CYC - 1));
        if (last) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end
      end
      GAP: begin
        last = (cnt == CW'(HALF - 1));
        idx  = 4'd0;
        if (last) begin
          samp     = 1'b1;
          n_nx     = 5'd1;
          state_nx = LOW;
          cnt_nx   = '0;
        end
      end
      LOW: begin
        pclk = 1'b0;
        last = (cnt == CW'(HALF - 1));
        if (last) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end
      end
      HIGH: begin
        last = (cnt == CW'(HALF - 1));
        if (last) begin
          cnt_nx = '0;
          samp   = (n <= 5'd15);
          if (n == 5'd16) begin
            fin      = 1'b1;
            state_nx = DONE;
          end else begin
            n_nx     = n + 5'd1;
            state_nx = LOW;
          end
        end
      end
      DONE: begin
        valid    = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, counters and bit capture; bits 12..15 are not kept
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      n     <= '0;
      sh1   <= '0;
      sh2   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      n     <= n_nx;
      if (samp && idx < 4'd12) begin
        sh1[idx] <= s2[0];
        sh2[idx] <= s2[1];
      end
    end
  end

  // publish whole words on entry to DONE so they show with valid
  always_ff @(posedge clk) begin
    if (reset) begin
      p1data <= '0;
      p2data <= '0;
    end else if (fin) begin
      p1data <= ~sh1;
      p2data <= ~sh2;
    end
  end

endmodule

// File: doc/snes_poller.md
# snes_poller

Sequencer that polls both players' SNES-style controllers over a shared latch/clock pair and delivers debounced-by-frame 12-bit button words to the game logic. It generates the latch pulse and 16 controller clock pulses, shifts in each player's serial data line, and publishes `p1data`/`p2data` (1 = pressed) to the `multi` game core once per poll period with a one-cycle `valid` strobe.

## Interface

- `LATCH_CYC`, default 288: latch-high duration in `clk` cycles.
- `HALF`, default 144: controller-clock half period in `clk` cycles; must be ≥ 4.
- `PERIOD`, default 400000: cycles between successive latch rising edges; must exceed `LATCH_CYC + 33*HALF + 1`.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `p1ser`  in  1  player-1 serial data, active-low (0 = pressed), asynchronous.
- `p2ser`  in  1  player-2 serial data, active-low, asynchronous.
- `latch`  out  1  controller latch, shared by both pads.
- `pclk`  out  1  controller clock, shared, idles high.
- `p1data`  out  12  player-1 buttons, 1 = pressed; bit k = serial bit k (B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R).
- `p2data`  out  12  player-2 buttons, same mapping.
- `valid`  out  1  one-cycle strobe: `p1data`/`p2data` just updated.

## Operation

- `p1ser`/`p2ser` each pass through a 2-flop synchronizer; all sampling uses synchronized values.
- Poll timer: counts 0..PERIOD-1 and wraps; a poll starts in the IDLE cycle where timer = 0. Timer is 0 in the first cycle after reset deasserts.
- States:
  - IDLE: `latch`=0, `pclk`=1. Timer = 0 → LATCH.
  - LATCH: `latch`=1, `pclk`=1 for LATCH_CYC cycles → GAP.
  - GAP: `latch`=0, `pclk`=1 for HALF cycles; on its last cycle sample bit 0 of both lines → LOW with pulse count n=1.
  - LOW: `pclk`=0 for HALF cycles → HIGH.
  - HIGH: `pclk`=1 for HALF cycles; on its last cycle, if n ≤ 15 sample bit n. n=16 → DONE, else n+1 → LOW.
  - DONE: one cycle; load `p1data` = ~shift1[11:0], `p2data` = ~shift2[11:0], `valid`=1 → IDLE.
- Sixteen clock pulses per poll; bits 12..15 are sampled into the shift register but discarded.
- Outputs hold their last values between DONE cycles; a poll never partially updates them.
- Disconnected pad with pull-up reads all 1s → reported as 0 (nothing pressed); no presence detection.

## Timing

- Cycle 0 = first LATCH cycle. `latch` high cycles 0..LATCH_CYC-1.
- First `pclk` falling edge at cycle LATCH_CYC+HALF; pulse n falls at LATCH_CYC+(2n-1)·HALF and rises HALF cycles later.
- Bit 0 sampled at cycle LATCH_CYC+HALF-1; bit n sampled at cycle LATCH_CYC+(2n+1)·HALF-1.
- `valid` high and new data visible in cycle LATCH_CYC+33·HALF only.
- Next latch rise at cycle PERIOD.
- Synchronizer latency of 2 cycles is covered by HALF ≥ 4. Data on the pad lines must be stable from HALF/2 cycles after the preceding edge onward.
- Reset values: `latch`=0, `pclk`=1, `p1data`=0, `p2data`=0, `valid`=0. Shift registers, pulse count, and timer are cleared, and the state is IDLE.
- Reset mid-poll aborts it: outputs take reset values the next cycle, no `valid` from the aborted poll, and a fresh poll begins at cycle 0 after release.

## Test plan

Bench parameters: LATCH_CYC=8, HALF=4, PERIOD=300. Pad models shift on `latch` fall and on each `pclk` rise.

- Reset then release, both pads released (lines high):
  - `latch` high cycles 0–7.
  - 16 `pclk` low pulses, first falling at cycle 12.
  - `valid` only at cycle 140, with `p1data`=`p2data`=0.
- P1 pressing 12'hA5F, P2 pressing 12'h001 → at the `valid` cycle `p1data`=12'hA5F, `p2data`=12'h001, checking bit order and independence.
- P1 drives serial bits 12–15 low, buttons 12'h000 → `p1data`=12'h000.
- Change P1 from 12'h0F0 to 12'h00F at cycle 200:
  - `p1data` stays 12'h0F0 through cycle 439.
  - Second latch rises at 300.
  - `p1data` becomes 12'h00F at the second `valid` (cycle 440).
- Assert `reset` during pulse 7 for 1 cycle:
  - Next cycle `latch`=0, `pclk`=1, data=0, `valid`=0.
  - After release, a full poll restarts, and `valid` occurs exactly 140 cycles after restart.
- Pad toggles its line during a `pclk`-low phase, away from sample points → captured value matches the level at the sample cycle only.
